// File: rtl/mc_dmem_arbiter.sv
// mc_dmem_arbiter: shared single-port data RAM front end for NCORE cores.
// Cores get round-robin access while in run. The com port owns the RAM in
// load and readback. Per-core end_process flags fold into a sticky all_done.
// Optional statistics outputs are enabled with `define MC_DMEM_ARB_STATS_EN.
module mc_dmem_arbiter #(
    parameter int unsigned NCORE = 3,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          status,
    input  logic                com_wr_en,
    input  logic [AW-1:0]       com_addr,
    input  logic [DW-1:0]       com_data_in,
    output logic [DW-1:0]       com_data_out,
    output logic                com_rvalid,
    input  logic [NCORE-1:0]    core_req,
    input  logic [NCORE-1:0]    core_wr_en,
    input  logic [NCORE*AW-1:0] core_addr,
    input  logic [NCORE*DW-1:0] core_wdata,
    output logic [NCORE-1:0]    core_gnt,
    output logic [NCORE-1:0]    core_rvalid,
    output logic [DW-1:0]       core_rdata,
    input  logic [NCORE-1:0]    core_done,
    output logic                all_done,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
`ifdef MC_DMEM_ARB_STATS_EN
    ,
    output logic [15:0]         stat_conflict,
    output logic [7:0]          stat_maxwait
`endif
);

    localparam int unsigned PW = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam logic [1:0] ST_RUN      = 2'b01;
    localparam logic [1:0] ST_READBACK = 2'b10;

    logic             is_run;
    logic             is_readback;
    logic             prev_run;
    logic             run_entry;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    rr_next;
    logic [PW-1:0]    winner;
    logic             found;
    logic [PW:0]      idx_sum;
    logic [PW-1:0]    idx;
    logic [DW-1:0]    com_data_q;
    logic [NCORE-1:0] done_sticky;
    logic             com_rd;

    assign is_run      = (status == ST_RUN);
    assign is_readback = (status == ST_READBACK);
    assign run_entry   = is_run && !prev_run;
    // Status 11 behaves as load: anything other than a load-status write is a com read.
    assign com_rd      = !is_run && !(com_wr_en && !is_readback);

    // Round-robin search starting at rr_ptr, wrapping modulo NCORE.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NCORE; k++) begin
            idx_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx_sum >= (PW+1)'(NCORE)) begin
                idx_sum = idx_sum - (PW+1)'(NCORE);
            end
            idx = idx_sum[PW-1:0];
            if (!found && core_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign rr_next = (winner == PW'(NCORE - 1)) ? '0 : winner + PW'(1);

    // RAM port mux: winning core lane in run, com port otherwise.
    always_comb begin
        core_gnt  = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (is_run) begin
            for (int unsigned i = 0; i < NCORE; i++) begin
                if (found && (winner == PW'(i))) begin
                    core_gnt[i] = 1'b1;
                    mem_we      = core_wr_en[i];
                    mem_addr    = core_addr[i*AW +: AW];
                    mem_wdata   = core_wdata[i*DW +: DW];
                end
            end
        end else begin
            mem_we    = com_wr_en && !is_readback;
            mem_addr  = com_addr;
            mem_wdata = com_data_in;
        end
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // Read-return tags, round-robin pointer, com data hold and done tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            core_rvalid <= '0;
            com_rvalid  <= 1'b0;
            com_data_q  <= '0;
            done_sticky <= '0;
            all_done    <= 1'b0;
            prev_run    <= 1'b0;
        end else begin
            if (is_run && found) begin
                rr_ptr <= rr_next;
            end
            core_rvalid <= is_run ? (core_gnt & ~core_wr_en) : '0;
            com_rvalid  <= com_rd;
            if (com_rvalid) begin
                com_data_q <= mem_rdata;
            end
            prev_run <= is_run;
            if (run_entry) begin
                done_sticky <= '0;
                all_done    <= 1'b0;
            end else if (is_run) begin
                done_sticky <= done_sticky | core_done;
                all_done    <= &(done_sticky | core_done);
            end
        end
    end

    assign com_data_out = com_rvalid ? mem_rdata : com_data_q;
    assign core_rdata   = mem_rdata;

`ifdef MC_DMEM_ARB_STATS_EN
    logic [7:0] wait_cnt [NCORE];
    logic [7:0] grant_wait;
    logic       multi_req;

    assign multi_req = ($countones(core_req) > 1);

    // Wait count of the core being granted this cycle.
    always_comb begin
        grant_wait = '0;
        for (int unsigned i = 0; i < NCORE; i++) begin
            if (core_gnt[i]) begin
                grant_wait = wait_cnt[i];
            end
        end
    end

    // Conflict-cycle counter, per-core wait counters and maximum wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_conflict <= '0;
            stat_maxwait  <= '0;
            for (int unsigned i = 0; i < NCORE; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (run_entry) begin
                stat_conflict <= multi_req ? 16'd1 : 16'd0;
            end else if (is_run && multi_req && (stat_conflict != 16'hFFFF)) begin
                stat_conflict <= stat_conflict + 16'd1;
            end
            for (int unsigned i = 0; i < NCORE; i++) begin
                if (is_run && core_req[i] && !core_gnt[i]) begin
                    if (wait_cnt[i] != 8'hFF) begin
                        wait_cnt[i] <= wait_cnt[i] + 8'd1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
            if (is_run && found && (grant_wait > stat_maxwait)) begin
                stat_maxwait <= grant_wait;
            end
        end
    end
`endif

endmodule
